uart_echo_sched: RTL

- Sequencer between the UART receiver and the UART transmitter in the echo design.
- Accepts each byte announced by the receiver's one-cycle `rcv` pulse and queues it in a small synchronous FIFO.
- Drives the transmitter's start/ready handshake so queued bytes go out strictly in arrival order.
- Reports FIFO fill level and a sticky overflow flag for LEDs/debug.

---
 rtl/uart_echo_sched_pkg.sv | 15 +
 rtl/uart_echo_sched_fifo_sync.sv | 75 +++++++
 rtl/uart_echo_sched.sv | 114 +++++++++++
 3 files changed

// File: rtl/uart_echo_sched_pkg.sv
// uart_echo_sched_pkg
//   Shared definitions for the UART echo sequencer: the transmit FSM state
//   encoding and the default FIFO depth.
package uart_echo_sched_pkg;

   localparam int DEFAULT_DEPTH = 4;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      START     = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } state_t;

endpackage

// File: rtl/uart_echo_sched_fifo_sync.sv
// fifo_sync
//   Small synchronous FIFO with show-ahead output.
//   Ports:
//     clk    system clock
//     rstn   synchronous reset, active low (empties the FIFO)
//     push   write din this cycle (ignored when full unless a pop frees a slot)
//     din    write data
//     pop    read the head this cycle (ignored when empty)
//     dout   current head entry, combinational from the read pointer
//     count  occupancy, 0..2**AW
//     full   count == 2**AW
//     empty  count == 0
module fifo_sync #(
   parameter int DW = 8,
   parameter int AW = 2
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          push,
   input  logic [DW-1:0] din,
   input  logic          pop,
   output logic [DW-1:0] dout,
   output logic [AW:0]   count,
   output logic          full,
   output logic          empty
);

   localparam int DEPTH = 1 << AW;

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [AW:0]   count_reg;
   logic          pop_ok;
   logic          push_ok;

   assign empty  = (count_reg == '0);
   assign full   = (count_reg == (AW+1)'(DEPTH));
   assign pop_ok = pop && !empty;
   // A pop in the same cycle frees the slot, so a push into a full FIFO is
   // still accepted when the head is leaving.
   assign push_ok = push && (!full || pop_ok);

   assign dout  = mem[rd_ptr_reg];
   assign count = count_reg;

   // Storage has no reset so it maps onto distributed/block memory.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr_reg] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         // Pointers are exactly AW bits wide, so they wrap modulo DEPTH.
         if (push_ok) begin
            wr_ptr_reg <= wr_ptr_reg + {{(AW-1){1'b0}}, 1'b1};
         end
         if (pop_ok) begin
            rd_ptr_reg <= rd_ptr_reg + {{(AW-1){1'b0}}, 1'b1};
         end
         case ({push_ok, pop_ok})
            2'b10:   count_reg <= count_reg + {{AW{1'b0}}, 1'b1};
            2'b01:   count_reg <= count_reg - {{AW{1'b0}}, 1'b1};
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/uart_echo_sched.sv
// uart_echo_sched
//   Sequencer between the UART receiver and transmitter of the echo design.
//   Received bytes are queued in a FIFO and handed to the transmitter one at
//   a time, in arrival order, using its start/ready handshake.
//   Ports:
//     clk       system clock (12 MHz)
//     rstn      synchronous reset, active low
//     rcv       one-cycle pulse: rx_data holds a new byte
//     rx_data   byte from the receiver
//     tx_ready  transmitter idle (1) / busy (0)
//     tx_start  one-cycle pulse: transmitter loads tx_data
//     tx_data   byte to transmit, stable until the transmitter is idle again
//     ovf_clr   clears ovf
//     ovf       sticky: a byte was dropped because the FIFO was full
//     count     FIFO occupancy, 0..DEPTH
module uart_echo_sched
   import uart_echo_sched_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int AW    = 2
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        rcv,
   input  logic [7:0]  rx_data,
   input  logic        tx_ready,
   output logic        tx_start,
   output logic [7:0]  tx_data,
   input  logic        ovf_clr,
   output logic        ovf,
   output logic [AW:0] count
);

   // DEPTH is informational; the FIFO size follows AW. Catch a mismatch at
   // elaboration instead of building a silently different FIFO.
   if ((1 << AW) != DEPTH) begin : g_bad_depth
      $error("uart_echo_sched: DEPTH must equal 2**AW");
   end

   state_t     state_reg;
   logic       pop;
   logic       drop;
   logic [7:0] fifo_dout;
   logic       fifo_full;
   logic       fifo_empty;

   // The head leaves the FIFO on the same edge the FSM leaves IDLE.
   assign pop  = (state_reg == IDLE) && !fifo_empty && tx_ready;
   // A byte is lost only if the FIFO is full and no slot frees this cycle.
   assign drop = rcv && fifo_full && !pop;

   fifo_sync #(
      .DW (8),
      .AW (AW)
   ) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .push  (rcv),
      .din   (rx_data),
      .pop   (pop),
      .dout  (fifo_dout),
      .count (count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // tx_start is the registered output of the START state, so the pulse is
   // seen by the transmitter on the cycle after START. WAIT_BUSY then waits
   // for ready to drop, which tolerates a transmitter that reacts late.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_reg <= IDLE;
         tx_start  <= 1'b0;
         tx_data   <= 8'h00;
      end else begin
         tx_start <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (pop) begin
                  tx_data   <= fifo_dout;
                  state_reg <= START;
               end
            end
            START: begin
               tx_start  <= 1'b1;
               state_reg <= WAIT_BUSY;
            end
            WAIT_BUSY: begin
               if (!tx_ready) begin
                  state_reg <= WAIT_DONE;
               end
            end
            WAIT_DONE: begin
               if (tx_ready) begin
                  state_reg <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   // Overflow set takes priority over a simultaneous clear.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         ovf <= 1'b0;
      end else if (drop) begin
         ovf <= 1'b1;
      end else if (ovf_clr) begin
         ovf <= 1'b0;
      end
   end

endmodule
